// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and control-state encodings.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
// master = producer/consumer side, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ALUop1;
    logic [WIDTH-1:0] ALUop2;
    logic [3:0]       ALUctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUout;
    logic             EQ;

    modport master (
        output in_valid, ALUop1, ALUop2, ALUctrl, out_ready,
        input  in_ready, out_valid, ALUout, EQ
    );

    modport slave (
        input  in_valid, ALUop1, ALUop2, ALUctrl, out_ready,
        output in_ready, out_valid, ALUout, EQ
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add unsigned multiplier, one partial product per cycle.
// A start pulse loads the operands; o_done pulses one cycle after the
// last of WIDTH iterations, with the full 2*WIDTH product on o_prod.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);
    localparam int SHW = $clog2(WIDTH);

    logic               r_busy;
    logic               r_done;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_a;
    logic [WIDTH-1:0]   r_b;

    // Load on start, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_a    <= {{WIDTH{1'b0}}, i_a};
                r_b    <= i_b;
                r_acc  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_b[0]) r_acc <= r_acc + r_a;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + SHW'(1);
                if (r_cnt == SHW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_prod = r_acc;
endmodule

// File: rtl/alu_seq.sv
// Sequential execute-stage ALU with valid/ready on both sides and a
// registered result. Optional iterative multiplier enabled by ALU_MUL_EN;
// without it, codes 10/11 behave as undefined single-cycle ops (result 0).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e         r_state;
    logic [WIDTH-1:0]   r_out;
    logic               r_eq;
    logic               r_hi;

    logic [WIDTH-1:0]   w_res;
    logic [SHW-1:0]     w_sh;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    assign w_sh     = bus.ALUop2[SHW-1:0];
    assign w_accept = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
    logic w_mul_start;
    assign w_is_mul    = (bus.ALUctrl == OP_MUL) || (bus.ALUctrl == OP_MULHU);
    assign w_mul_start = w_accept && w_is_mul;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mul_start),
        .i_a     (bus.ALUop1),
        .i_b     (bus.ALUop2),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_prod     = '0;
`endif

    // Single-cycle result; multiply codes and undefined codes yield zero here.
    always_comb begin
        w_res = '0;
        case (bus.ALUctrl)
            OP_ADD:  w_res = bus.ALUop1 + bus.ALUop2;
            OP_SUB:  w_res = bus.ALUop1 - bus.ALUop2;
            OP_AND:  w_res = bus.ALUop1 & bus.ALUop2;
            OP_OR:   w_res = bus.ALUop1 | bus.ALUop2;
            OP_XOR:  w_res = bus.ALUop1 ^ bus.ALUop2;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.ALUop1) < $signed(bus.ALUop2))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.ALUop1 < bus.ALUop2)};
            OP_SLL:  w_res = bus.ALUop1 << w_sh;
            OP_SRL:  w_res = bus.ALUop1 >> w_sh;
            OP_SRA:  w_res = $signed(bus.ALUop1) >>> w_sh;
            default: w_res = '0;
        endcase
    end

    // Control FSM: accepts directly from IDLE or, back-to-back, from DONE as the result drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_eq    <= 1'b0;
            r_hi    <= 1'b0;
        end else if (w_accept) begin
            r_eq <= (bus.ALUop1 == bus.ALUop2);
            r_hi <= (bus.ALUctrl == OP_MULHU);
            if (w_is_mul) begin
                r_state <= MUL;
            end else begin
                r_state <= DONE;
                r_out   <= w_res;
            end
        end else begin
            case (r_state)
                MUL: begin
                    if (w_mul_done) begin
                        r_out   <= r_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) r_state <= IDLE;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign bus.out_valid = (r_state == DONE);
    assign bus.ALUout    = r_out;
    assign bus.EQ        = r_eq;
endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomised bench for alu_seq (WIDTH=32). Honours ALU_MUL_EN.
module tb_alu_seq;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.ALUctrl  = op;
        bus.ALUop1   = a;
        bus.ALUop2   = b;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.ALUctrl = 4'd0; bus.ALUop1 = 32'd0; bus.ALUop2 = 32'd0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ALUout !== 32'd0 || bus.EQ !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset got valid=%b out=%h eq=%b rdy=%b exp 0/0/0/1",
                     bus.out_valid, bus.ALUout, bus.EQ, bus.in_ready);
        end
    endtask

    task automatic test_sub_add();
        bus.out_ready = 1'b1;
        drive(4'd1, 32'd5, 32'd7);
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.ALUout !== 32'hFFFF_FFFE || bus.EQ !== 1'b0) begin
            failures++;
            $display("FAIL sub got valid=%b out=%h eq=%b exp 1/fffffffe/0",
                     bus.out_valid, bus.ALUout, bus.EQ);
        end
        drive(4'd0, 32'd7, 32'd7);
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.ALUout !== 32'd14 || bus.EQ !== 1'b1) begin
            failures++;
            $display("FAIL add got valid=%b out=%h eq=%b exp 1/0000000e/1",
                     bus.out_valid, bus.ALUout, bus.EQ);
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain got valid=%b exp 0", bus.out_valid);
        end
    endtask

    // Back-to-back directed vectors, one result per cycle.
    task automatic test_back_to_back();
        logic [3:0]  ops [12] = '{4'd5, 4'd6, 4'd9, 4'd7, 4'd8, 4'd2, 4'd3, 4'd4, 4'd13, 4'd0, 4'd5, 4'd1};
        logic [31:0] as  [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001,
                                  32'h8000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                  32'd5, 32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [31:0] bs  [12] = '{32'd1, 32'd1, 32'h0000_0021, 32'hFFFF_FFE3,
                                  32'd4, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
                                  32'd5, 32'd1, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] es  [12] = '{32'd1, 32'd0, 32'hC000_0000, 32'd8,
                                  32'h0800_0000, 32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0,
                                  32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic        eqs [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(ops[i], as[i], bs[i]);
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.ALUout !== es[i] || bus.EQ !== eqs[i]) begin
                failures++;
                $display("FAIL vec%0d op=%0d got valid=%b out=%h eq=%b exp 1/%h/%b",
                         i, ops[i], bus.out_valid, bus.ALUout, bus.EQ, es[i], eqs[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(4'd4, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        drive(4'd0, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.ALUout !== 32'h0000_0FF0 || bus.EQ !== 1'b0 ||
                bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall%0d got valid=%b out=%h eq=%b rdy=%b exp 1/00000ff0/0/0",
                         i, bus.out_valid, bus.ALUout, bus.EQ, bus.in_ready);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready got %b exp 1", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.ALUout !== 32'd3) begin
            failures++;
            $display("FAIL no_bubble got valid=%b out=%h exp 1/00000003", bus.out_valid, bus.ALUout);
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_mul();
        logic [31:0] exp_r [2] = '{32'd0, 32'd3};
        logic [3:0]  ops   [2] = '{4'd10, 4'd11};
        bus.out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            int lat;
            logic rdy_bad;
            drive(ops[j], 32'h0001_0000, 32'h0003_0000);
            step();
            bus.in_valid = 1'b0;
`ifdef ALU_MUL_EN
            lat = 0;
            rdy_bad = 1'b0;
            while (lat < 40 && bus.out_valid !== 1'b1) begin
                if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
                step();
                lat++;
            end
            checks++;
            if (lat != 33) begin
                failures++;
                $display("FAIL mul%0d_latency got %0d exp 33", j, lat);
            end
            checks++;
            if (rdy_bad) begin
                failures++;
                $display("FAIL mul%0d_in_ready got 1 during MUL exp 0", j);
            end
            exp_r[1] = 32'd3;
`else
            lat = 1;
            rdy_bad = 1'b0;
            exp_r[1] = 32'd0;
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL mul%0d_undef_valid got %b exp 1", j, bus.out_valid);
            end
`endif
            checks++;
            if (bus.ALUout !== exp_r[j] || bus.EQ !== 1'b0) begin
                failures++;
                $display("FAIL mul%0d_result got out=%h eq=%b exp %h/0", j, bus.ALUout, bus.EQ, exp_r[j]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.out_ready = 1'b0;
`ifdef ALU_MUL_EN
        drive(4'd10, 32'h0001_0000, 32'h0003_0000);
`else
        drive(4'd0, 32'd1, 32'd1);
`endif
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ALUout !== 32'd0 || bus.EQ !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got valid=%b out=%h eq=%b rdy=%b exp 0/0/0/1",
                     bus.out_valid, bus.ALUout, bus.EQ, bus.in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_abandon got out_valid=1 after reset exp 0");
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_random();
        logic        m_valid;
        logic [31:0] m_res;
        logic        m_eq;
        logic        m_rdy;
        int          accepted;
        int          cycles;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step(); step();
        m_valid = 1'b0; m_res = '0; m_eq = 1'b0;
        accepted = 0;
        cycles = 0;
        while (accepted < 10000 && cycles < 40000) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
            if (op == 4'd10 || op == 4'd11) op = 4'd12;
`endif
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.ALUctrl   = op;
            bus.ALUop1    = $urandom;
            bus.ALUop2    = ($urandom_range(0, 7) == 0) ? bus.ALUop1 : $urandom;
            #1;
            m_rdy = !m_valid || bus.out_ready;
            checks++;
            if (bus.out_valid !== m_valid || bus.in_ready !== m_rdy ||
                (m_valid && (bus.ALUout !== m_res || bus.EQ !== m_eq))) begin
                failures++;
                $display("FAIL rand cyc%0d got v=%b r=%b out=%h eq=%b exp v=%b r=%b out=%h eq=%b",
                         cycles, bus.out_valid, bus.in_ready, bus.ALUout, bus.EQ,
                         m_valid, m_rdy, m_res, m_eq);
            end
            if (bus.in_valid && m_rdy) begin
                m_valid = 1'b1;
                m_res   = ref_alu(op, bus.ALUop1, bus.ALUop2);
                m_eq    = (bus.ALUop1 == bus.ALUop2);
                accepted++;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        checks++;
        if (accepted < 10000) begin
            failures++;
            $display("FAIL rand_budget got %0d ops exp 10000", accepted);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sub_add();
        test_back_to_back();
        test_backpressure();
        test_mul();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
